// File: rtl/frame_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : frame_stream_reader
//  Description : Plays a stored grayscale frame out of a synchronous-read
//                memory as a valid/ready pixel stream with sof/eol/eof flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_stream_reader #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int W          = 8,
    parameter int ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [W-1:0]      mem_rd_data,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [W-1:0]      y_data,
    output logic              y_sof,
    output logic              y_eol,
    output logic              y_eof
);

    localparam int c_PIX   = IMG_WIDTH * IMG_HEIGHT;
    localparam int c_COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int c_ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic                 r_inflight;
    logic [1:0]           r_cnt;
    logic [W-1:0]         r_head;
    logic [W-1:0]         r_tail;
    logic [c_COL_W-1:0]   r_col;
    logic [c_ROW_W-1:0]   r_row;
    logic                 r_done;

    logic                 w_pop;
    logic                 w_push;
    logic                 w_last_rd;
    logic                 w_col_last;
    logic                 w_row_last;
    logic                 w_last_px;
    logic [2:0]           w_occ;

    assign w_pop      = y_valid && y_ready;
    assign w_push     = r_inflight;
    assign w_col_last = (r_col == c_COL_W'(IMG_WIDTH - 1));
    assign w_row_last = (r_row == c_ROW_W'(IMG_HEIGHT - 1));
    assign w_last_px  = w_col_last && w_row_last;
    assign w_last_rd  = (r_rd_addr == ADDR_W'(c_PIX - 1));

    // Credit: entries held plus the read in flight, minus the one leaving now.
    assign w_occ      = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign mem_rd_en  = (r_state == S_RUN) && !abort && (w_occ < 3'd2);
    assign mem_addr   = r_rd_addr;

    assign y_valid    = (r_cnt != 2'd0);
    assign y_data     = r_head;
    assign y_sof      = y_valid && (r_row == '0) && (r_col == '0);
    assign y_eol      = y_valid && w_col_last;
    assign y_eof      = y_valid && w_last_px;

    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)                  w_state_nxt = S_RUN;
            S_RUN:   if (mem_rd_en && w_last_rd) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_pop && w_last_px)     w_state_nxt = S_IDLE;
            default:                             w_state_nxt = S_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b0;
            r_inflight <= 1'b0;
            r_cnt      <= 2'd0;
            r_head     <= '0;
            r_tail     <= '0;
            r_rd_addr  <= '0;
            r_col      <= '0;
            r_row      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == S_DRAIN) && w_pop && w_last_px && !abort;

            // Abort drops queued pixels and the pending read return.
            if (abort) begin
                r_inflight <= 1'b0;
                r_cnt      <= 2'd0;
            end else begin
                r_inflight <= mem_rd_en;
                case ({w_push, w_pop})
                    2'b10: begin
                        if (r_cnt == 2'd0) r_head <= mem_rd_data;
                        else               r_tail <= mem_rd_data;
                        r_cnt <= r_cnt + 2'd1;
                    end
                    2'b01: begin
                        r_head <= r_tail;
                        r_cnt  <= r_cnt - 2'd1;
                    end
                    2'b11: begin
                        if (r_cnt == 2'd1) begin
                            r_head <= mem_rd_data;
                        end else begin
                            r_head <= r_tail;
                            r_tail <= mem_rd_data;
                        end
                    end
                    default: ;
                endcase
            end

            if ((r_state == S_IDLE) && start) begin
                r_rd_addr <= '0;
                r_col     <= '0;
                r_row     <= '0;
            end else begin
                if (mem_rd_en && !w_last_rd) begin
                    r_rd_addr <= r_rd_addr + ADDR_W'(1);
                end
                if (w_pop) begin
                    if (w_col_last) begin
                        r_col <= '0;
                        r_row <= w_row_last ? '0 : r_row + c_ROW_W'(1);
                    end else begin
                        r_col <= r_col + c_COL_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !abort) begin
            assert (!(w_push && !w_pop && (r_cnt == 2'd2)))
                else $error("frame_stream_reader: output FIFO overflow");
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_stream_reader
//  Description : Directed self-checking bench for frame_stream_reader (4x3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       mem_rd_en;
    logic [3:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       y_valid;
    logic       y_ready;
    logic [7:0] y_data;
    logic       y_sof;
    logic       y_eol;
    logic       y_eof;

    int total = 0;
    int bad   = 0;

    frame_stream_reader #(
        .IMG_WIDTH (4),
        .IMG_HEIGHT(3),
        .W         (8),
        .ADDR_W    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .y_data     (y_data),
        .y_sof      (y_sof),
        .y_eol      (y_eol),
        .y_eof      (y_eof)
    );

    always #5 clk = ~clk;

    // Frame memory: mem[a] = a + 0x10, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= {4'h0, mem_addr} + 8'h10;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_px(input int k);
        chk("px_valid", 32'(y_valid), 32'd1);
        chk("px_data",  32'(y_data),  32'(16 + k));
        chk("px_sof",   32'(y_sof),   32'(k == 0));
        chk("px_eol",   32'(y_eol),   32'(k % 4 == 3));
        chk("px_eof",   32'(y_eof),   32'(k == 11));
        chk("px_done",  32'(done),    32'd0);
        chk("px_busy",  32'(busy),    32'd1);
    endtask

    // Issue start from a negedge; returns at the negedge where pixel 0 is shown.
    task automatic begin_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("bf_busy",   32'(busy),      32'd1);
        chk("bf_rd0",    32'(mem_rd_en), 32'd1);
        chk("bf_addr0",  32'(mem_addr),  32'd0);
        chk("bf_valid0", 32'(y_valid),   32'd0);
        @(negedge clk);
        chk("bf_rd1",    32'(mem_rd_en), 32'd1);
        chk("bf_addr1",  32'(mem_addr),  32'd1);
        chk("bf_valid1", 32'(y_valid),   32'd0);
        @(negedge clk);
    endtask

    // With y_ready=1 from pixel `from`, expects one pixel per cycle then done.
    task automatic expect_run(input int from, input int start_at);
        for (int k = from; k < 12; k++) begin
            check_px(k);
            start = (k == start_at);
            @(negedge clk);
        end
        start = 1'b0;
        chk("end_done",  32'(done),    32'd1);
        chk("end_busy",  32'(busy),    32'd0);
        chk("end_valid", 32'(y_valid), 32'd0);
    endtask

    initial begin
        int         exp_idx;
        int         issued;
        int         popped;
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       done_seen;

        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        y_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_rd",    32'(mem_rd_en), 32'd0);
        chk("rst_addr",  32'(mem_addr),  32'd0);
        chk("rst_valid", 32'(y_valid),   32'd0);
        chk("rst_side",  32'({y_sof, y_eol, y_eof}), 32'd0);

        // 1: full-rate frame
        y_ready = 1'b1;
        begin_frame();
        expect_run(0, -1);
        @(negedge clk);
        chk("t1_done_once", 32'(done), 32'd0);

        // 2: random backpressure
        exp_idx = 0; issued = 0; popped = 0;
        prev_stall = 1'b0; prev_data = 8'h00; done_seen = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 400 && !done_seen; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                done_seen = 1'b1;
            end else begin
                if (prev_stall) begin
                    chk("t2_hold_valid", 32'(y_valid), 32'd1);
                    chk("t2_hold_data",  32'(y_data),  32'(prev_data));
                end
                if (y_valid) begin
                    chk("t2_data", 32'(y_data), 32'(16 + exp_idx));
                    chk("t2_sof",  32'(y_sof),  32'(exp_idx == 0));
                    chk("t2_eol",  32'(y_eol),  32'(exp_idx % 4 == 3));
                    chk("t2_eof",  32'(y_eof),  32'(exp_idx == 11));
                end
                y_ready = 1'($urandom_range(0, 1));
                #1;
                if (mem_rd_en) issued++;
                if (y_valid && y_ready) begin
                    popped++;
                    exp_idx++;
                end
                chk("t2_credit", 32'((issued - popped) <= 2), 32'd1);
                prev_stall = y_valid && !y_ready;
                prev_data  = y_data;
            end
        end
        chk("t2_done_seen", 32'(done_seen), 32'd1);
        chk("t2_count",     32'(exp_idx),   32'd12);
        chk("t2_reads",     32'(issued),    32'd12);
        chk("t2_busy",      32'(busy),      32'd0);

        // 3: stall from the first valid, then release
        y_ready = 1'b0;
        @(negedge clk);
        begin_frame();
        for (int c = 0; c < 10; c++) begin
            chk("t3_rd_stall", 32'(mem_rd_en), 32'd0);
            chk("t3_valid",    32'(y_valid),   32'd1);
            chk("t3_data",     32'(y_data),    32'h10);
            @(negedge clk);
        end
        y_ready = 1'b1;
        expect_run(0, -1);

        // 4: start mid-frame ignored; start in done cycle accepted
        @(negedge clk);
        begin_frame();
        expect_run(0, 5);
        begin_frame();
        chk("t4_no_extra_done", 32'(done), 32'd0);
        expect_run(0, -1);

        // 5: abort after 5 transfers
        @(negedge clk);
        begin_frame();
        for (int k = 0; k < 5; k++) begin
            check_px(k);
            @(negedge clk);
        end
        check_px(5);
        y_ready = 1'b0;
        abort   = 1'b1;
        @(negedge clk);
        abort   = 1'b0;
        y_ready = 1'b1;
        chk("t5_valid", 32'(y_valid),   32'd0);
        chk("t5_busy",  32'(busy),      32'd0);
        chk("t5_done",  32'(done),      32'd0);
        chk("t5_rd",    32'(mem_rd_en), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5_quiet_valid", 32'(y_valid), 32'd0);
            chk("t5_quiet_done",  32'(done),    32'd0);
        end
        begin_frame();
        expect_run(0, -1);

        // 6: reset mid-frame under stall
        @(negedge clk);
        y_ready = 1'b0;
        begin_frame();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_busy",  32'(busy),      32'd0);
        chk("t6_done",  32'(done),      32'd0);
        chk("t6_rd",    32'(mem_rd_en), 32'd0);
        chk("t6_addr",  32'(mem_addr),  32'd0);
        chk("t6_valid", 32'(y_valid),   32'd0);
        chk("t6_side",  32'({y_sof, y_eol, y_eof}), 32'd0);
        y_ready = 1'b1;
        @(negedge clk);
        begin_frame();
        expect_run(0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
